// File: rtl/display_scheduler_if.sv
// Signal bundle between the tracker counters and the display scheduler.
// The tracker side drives metrics and tick; the scheduler drives the scan outputs.
interface display_scheduler_if;
  logic        tick;
  logic        hold;
  logic [13:0] stepcnt;
  logic [8:0]  distance;
  logic [3:0]  sec;
  logic [8:0]  sectime;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic [1:0]  sel;
  logic        busy;

  modport master (
    output tick, hold, stepcnt, distance, sec, sectime,
    input  an, digit, sel, busy
  );

  modport slave (
    input  tick, hold, stepcnt, distance, sec, sectime,
    output an, digit, sel, busy
  );
endinterface

// File: rtl/display_scheduler.sv
// Rotates tracker metrics onto a 4-digit multiplexed display, converting each
// selected value to BCD with a 14-step sequential double-dabble engine.
module display_scheduler #(
  parameter int REFRESH_DIV = 100000,
  parameter int DWELL_TICKS = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  display_scheduler_if.slave bus
);

  localparam int SCAN_W  = $clog2(REFRESH_DIV);
  localparam int DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(REFRESH_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);
  localparam logic [3:0]         LAST_ITER  = 4'd13;
  localparam logic [13:0]        BCD_MAX    = 14'd9999;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_CONV = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic               load_en;
  logic               conv_en;
  logic               conv_done;
  logic               refresh_en;
  logic               tick_seen;

  logic [13:0]        metric_raw;
  logic [13:0]        metric_sat;
  logic [13:0]        bin_reg;
  logic [15:0]        bcd_reg;
  logic [3:0]         iter_reg;
  logic [15:0]        bcd_adj;
  logic [29:0]        dd_shift;
  logic [15:0]        disp_reg;

  logic [1:0]         sel_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic               pending_reg;
  logic               busy_reg;

  logic [SCAN_W-1:0]  scan_reg;
  logic [1:0]         idx_reg;
  logic [3:0]         an_reg;
  logic [3:0]         digit_reg;
  logic [3:0]         an_next;
  logic [3:0]         digit_next;
  logic [3:0]         blank;
  logic [3:0]         nib [4];

  genvar gi;

  // A tick that landed during a conversion is honoured on the first WAIT cycle.
  assign tick_seen = bus.tick | pending_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= ST_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD: state_next = ST_CONV;
      ST_CONV: if (iter_reg == LAST_ITER) state_next = ST_WAIT;
      ST_WAIT: if (tick_seen) state_next = ST_LOAD;
      default: state_next = ST_LOAD;
    endcase
  end

  always_comb begin
    load_en    = 1'b0;
    conv_en    = 1'b0;
    conv_done  = 1'b0;
    refresh_en = 1'b0;
    case (state_reg)
      ST_LOAD: load_en = 1'b1;
      ST_CONV: begin
        conv_en   = 1'b1;
        conv_done = (iter_reg == LAST_ITER);
      end
      ST_WAIT: refresh_en = tick_seen;
      default: ;
    endcase
  end

  always_comb begin
    case (sel_reg)
      2'd1:    metric_raw = {5'd0, bus.distance};
      2'd2:    metric_raw = {10'd0, bus.sec};
      2'd3:    metric_raw = {5'd0, bus.sectime};
      default: metric_raw = bus.stepcnt;
    endcase
  end

  assign metric_sat = (metric_raw > BCD_MAX) ? BCD_MAX : metric_raw;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign dd_shift = {bcd_adj, bin_reg} << 1;

  // The display register is written only with the final shift result, so the
  // scan never shows an intermediate accumulator value.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      iter_reg <= '0;
      disp_reg <= '0;
    end else begin
      if (load_en) begin
        bin_reg  <= metric_sat;
        bcd_reg  <= '0;
        iter_reg <= '0;
      end
      if (conv_en) begin
        bin_reg  <= dd_shift[13:0];
        bcd_reg  <= dd_shift[29:14];
        iter_reg <= iter_reg + 4'd1;
      end
      if (conv_done) begin
        disp_reg <= dd_shift[29:14];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sel_reg     <= '0;
      dwell_reg   <= '0;
      pending_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      busy_reg <= (state_next != ST_WAIT);
      if (state_reg == ST_WAIT) begin
        pending_reg <= 1'b0;
      end else if (bus.tick) begin
        pending_reg <= 1'b1;
      end
      if (refresh_en && !bus.hold) begin
        if (dwell_reg == DWELL_LAST) begin
          sel_reg   <= sel_reg + 2'd1;
          dwell_reg <= '0;
        end else begin
          dwell_reg <= dwell_reg + DWELL_W'(1);
        end
      end
    end
  end

  assign blank[0] = 1'b0;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = disp_reg[gi*4 +: 4];
    end
    // A digit position goes dark when it and every position above it are zero.
    for (gi = 1; gi < 4; gi++) begin : g_blank
      assign blank[gi] = ~|disp_reg[15:gi*4];
    end
  endgenerate

  assign an_next    = blank[idx_reg] ? 4'b1111 : ~(4'b0001 << idx_reg);
  assign digit_next = nib[idx_reg];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scan_reg  <= '0;
      idx_reg   <= '0;
      an_reg    <= 4'b1111;
      digit_reg <= '0;
    end else begin
      if (scan_reg == SCAN_LAST) begin
        scan_reg <= '0;
        idx_reg  <= idx_reg + 2'd1;
      end else begin
        scan_reg <= scan_reg + SCAN_W'(1);
      end
      an_reg    <= an_next;
      digit_reg <= digit_next;
    end
  end

  assign bus.an    = an_reg;
  assign bus.digit = digit_reg;
  assign bus.sel   = sel_reg;
  assign bus.busy  = busy_reg;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: expected (sel, BCD) pairs are queued
// on each tick and checked when a conversion completes and while the scan runs.
module tb_display_scheduler;
  localparam int RD = 4;
  localparam int DW = 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  display_scheduler_if bus();

  display_scheduler #(.REFRESH_DIV(RD), .DWELL_TICKS(DW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] bcd;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int sel_m = 0;
  int dwell_m = 0;

  logic [15:0] obs_val;
  logic [3:0]  obs_lit;
  logic [23:0] obs_cnt;
  int          obs_order_bad;
  int          obs_bad_an;

  function automatic logic [15:0] to_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] exp_lit(input int v);
    logic [3:0] m;
    m = 4'b0001;
    if (v >= 10)   m[1] = 1'b1;
    if (v >= 100)  m[2] = 1'b1;
    if (v >= 1000) m[3] = 1'b1;
    return m;
  endfunction

  function automatic logic [23:0] exp_cnt(input logic [3:0] lit);
    logic [23:0] r;
    r = '0;
    for (int p = 0; p < 4; p++) if (lit[p]) r[p*6 +: 6] = 6'(2 * RD);
    return r;
  endfunction

  function automatic int metric_now(input int s);
    int v;
    case (s)
      1:       v = int'(bus.distance);
      2:       v = int'(bus.sec);
      3:       v = int'(bus.sectime);
      default: v = int'(bus.stepcnt);
    endcase
    return v;
  endfunction

  task automatic model_tick();
    exp_t e;
    if (!bus.hold) begin
      if (dwell_m == DW - 1) begin
        sel_m   = (sel_m + 1) % 4;
        dwell_m = 0;
      end else begin
        dwell_m++;
      end
    end
    e.sel = 2'(sel_m);
    e.bcd = to_bcd(metric_now(sel_m));
    exp_q.push_back(e);
  endtask

  // Pulses tick for one cycle and waits (bounded) for the conversion to finish.
  task automatic tick_and_wait(output int hi, output bit ok);
    model_tick();
    bus.tick = 1'b1;
    hi = 0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      bus.tick = 1'b0;
      if (bus.busy) hi++;
      else if (hi > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Watches two full scan periods and reconstructs what the display shows.
  task automatic read_display();
    int prev_pos;
    int pos;
    prev_pos = -1;
    obs_val = '0;
    obs_lit = '0;
    obs_cnt = '0;
    obs_order_bad = 0;
    obs_bad_an = 0;
    for (int i = 0; i < 8 * RD; i++) begin
      @(negedge CLK);
      pos = -1;
      for (int p = 0; p < 4; p++) if (bus.an == ~(4'b0001 << p)) pos = p;
      if (pos >= 0) begin
        obs_val[pos*4 +: 4] = bus.digit;
        obs_lit[pos] = 1'b1;
        obs_cnt[pos*6 +: 6] = obs_cnt[pos*6 +: 6] + 6'd1;
        if (prev_pos >= 0 && pos != prev_pos && pos != (prev_pos + 1) % 4) obs_order_bad++;
        prev_pos = pos;
      end else begin
        if (bus.an != 4'b1111) obs_bad_an++;
        prev_pos = -1;
      end
    end
  endtask

  // Scoreboard monitor: pops on each completed conversion and checks every lit digit.
  logic [15:0] cur_exp = '0;
  logic [15:0] staged  = '0;
  bit          upd_pending = 1'b0;
  logic        prev_busy = 1'b0;
  exp_t        mon_e;

  always @(negedge CLK) begin
    if (!RESET) begin
      cur_exp     = '0;
      upd_pending = 1'b0;
      prev_busy   = 1'b0;
    end else begin
      if (upd_pending) begin
        cur_exp     = staged;
        upd_pending = 1'b0;
      end
      for (int p = 0; p < 4; p++) begin
        if (bus.an == ~(4'b0001 << p)) begin
          total++;
          if (bus.digit !== cur_exp[p*4 +: 4]) begin
            bad++;
            $display("FAIL sb_digit[%0d]: got %0d want %0d", p, bus.digit, cur_exp[p*4 +: 4]);
          end
          total++;
          if (p > 0 && (cur_exp >> (4 * p)) == 16'd0) begin
            bad++;
            $display("FAIL sb_blank[%0d]: lit with value %h, want dark", p, cur_exp);
          end
        end
      end
      if (prev_busy && !bus.busy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: conversion finished with sel=%0d, none expected", bus.sel);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.sel !== mon_e.sel) begin
            bad++;
            $display("FAIL sb_sel: got %0d want %0d", bus.sel, mon_e.sel);
          end
          staged      = mon_e.bcd;
          upd_pending = 1'b1;
        end
      end
      prev_busy = bus.busy;
    end
  end

  task automatic test_reset();
    int lat;
    bit ok;
    exp_t e;
    bus.tick = 1'b0; bus.hold = 1'b0;
    bus.stepcnt = 14'd1234; bus.distance = '0; bus.sec = '0; bus.sectime = '0;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (6) @(negedge CLK);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b want 1", bus.busy); end
    #2 RESET = 1'b0;
    #1;
    total++;
    if (bus.an !== 4'b1111) begin bad++; $display("FAIL rst_an: got %b want 1111", bus.an); end
    total++;
    if (bus.sel !== 2'd0) begin bad++; $display("FAIL rst_sel: got %0d want 0", bus.sel); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++;
    if (bus.digit !== 4'd0) begin bad++; $display("FAIL rst_digit: got %0d want 0", bus.digit); end
    exp_q.delete();
    sel_m = 0;
    dwell_m = 0;
    repeat (2) @(negedge CLK);
    e.sel = 2'd0;
    e.bcd = to_bcd(1234);
    exp_q.push_back(e);
    RESET = 1'b1;
    lat = 0;
    ok = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      if (bus.busy) lat = -i;
      else if (lat < 0) begin
        lat = i;
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || lat != 15) begin bad++; $display("FAIL rst_latency: got %0d want 15", lat); end
    read_display();
    total++;
    if (obs_val !== 16'h1234) begin bad++; $display("FAIL rst_val: got %h want 1234", obs_val); end
    total++;
    if (obs_lit !== 4'b1111) begin bad++; $display("FAIL rst_lit: got %b want 1111", obs_lit); end
    total++;
    if (obs_cnt !== exp_cnt(4'b1111)) begin bad++; $display("FAIL rst_hold_len: got %h want %h", obs_cnt, exp_cnt(4'b1111)); end
    total++;
    if (obs_order_bad != 0 || obs_bad_an != 0) begin bad++; $display("FAIL rst_scan_order: got order_err=%0d an_err=%0d want 0/0", obs_order_bad, obs_bad_an); end
  endtask

  task automatic test_saturate();
    int vals[5] = '{12000, 16383, 9999, 7, 0};
    int hi;
    bit ok;
    bus.hold = 1'b1;
    foreach (vals[i]) begin
      bus.stepcnt = 14'(vals[i]);
      tick_and_wait(hi, ok);
      total++;
      if (!ok || hi != 15) begin bad++; $display("FAIL sat_busy[%0d]: got %0d cycles want 15", i, hi); end
      total++;
      if (bus.sel !== 2'd0) begin bad++; $display("FAIL sat_sel[%0d]: got %0d want 0", i, bus.sel); end
      read_display();
      total++;
      if (obs_val !== to_bcd(vals[i])) begin bad++; $display("FAIL sat_val[%0d]: got %h want %h", i, obs_val, to_bcd(vals[i])); end
      total++;
      if (obs_lit !== exp_lit(vals[i])) begin bad++; $display("FAIL sat_lit[%0d]: got %b want %b", i, obs_lit, exp_lit(vals[i])); end
      total++;
      if (obs_cnt !== exp_cnt(exp_lit(vals[i]))) begin bad++; $display("FAIL sat_hold_len[%0d]: got %h want %h", i, obs_cnt, exp_cnt(exp_lit(vals[i]))); end
      total++;
      if (obs_order_bad != 0 || obs_bad_an != 0) begin bad++; $display("FAIL sat_scan[%0d]: got order_err=%0d an_err=%0d want 0/0", i, obs_order_bad, obs_bad_an); end
    end
  endtask

  task automatic test_rotation();
    int sel_tab[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    logic [15:0] val_tab[4] = '{16'h0100, 16'h0250, 16'h0009, 16'h0300};
    logic [3:0] lit_tab[4] = '{4'b0111, 4'b0111, 4'b0001, 4'b0111};
    int hi;
    bit ok;
    bus.hold = 1'b0;
    bus.stepcnt = 14'd100; bus.distance = 9'd250; bus.sec = 4'd9; bus.sectime = 9'd300;
    foreach (sel_tab[i]) begin
      tick_and_wait(hi, ok);
      total++;
      if (!ok || hi != 15) begin bad++; $display("FAIL rot_busy[%0d]: got %0d cycles want 15", i, hi); end
      total++;
      if (bus.sel !== 2'(sel_tab[i])) begin bad++; $display("FAIL rot_sel[%0d]: got %0d want %0d", i, bus.sel, sel_tab[i]); end
      read_display();
      total++;
      if (obs_val !== val_tab[sel_tab[i]]) begin bad++; $display("FAIL rot_val[%0d]: got %h want %h", i, obs_val, val_tab[sel_tab[i]]); end
      total++;
      if (obs_lit !== lit_tab[sel_tab[i]]) begin bad++; $display("FAIL rot_lit[%0d]: got %b want %b", i, obs_lit, lit_tab[sel_tab[i]]); end
    end
  endtask

  task automatic test_hold();
    logic [15:0] hold_tab[5] = '{16'h0005, 16'h0005, 16'h0006, 16'h0006, 16'h0006};
    int hi;
    bit ok;
    bus.hold = 1'b0;
    bus.stepcnt = 14'd5;
    tick_and_wait(hi, ok);
    read_display();
    total++;
    if (bus.sel !== 2'd0 || obs_val !== 16'h0005) begin bad++; $display("FAIL hold_pre: got sel=%0d val=%h want sel=0 val=0005", bus.sel, obs_val); end
    bus.hold = 1'b1;
    foreach (hold_tab[i]) begin
      tick_and_wait(hi, ok);
      if (i == 1) bus.stepcnt = 14'd6;
      total++;
      if (!ok || bus.sel !== 2'd0) begin bad++; $display("FAIL hold_sel[%0d]: got %0d want 0", i, bus.sel); end
      read_display();
      total++;
      if (obs_val !== hold_tab[i]) begin bad++; $display("FAIL hold_val[%0d]: got %h want %h", i, obs_val, hold_tab[i]); end
    end
    bus.hold = 1'b0;
    tick_and_wait(hi, ok);
    total++;
    if (!ok || bus.sel !== 2'd1) begin bad++; $display("FAIL hold_resume_sel: got %0d want 1", bus.sel); end
    read_display();
    total++;
    if (obs_val !== 16'h0250) begin bad++; $display("FAIL hold_resume_val: got %h want 0250", obs_val); end
  endtask

  task automatic test_back_to_back();
    int runs = 0;
    int len1 = 0;
    int len2 = 0;
    int gap  = 0;
    int cur  = 0;
    logic prev = 1'b0;
    bus.hold = 1'b0;
    model_tick();
    bus.tick = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      bus.tick = (n == 4 || n == 9);
      if (n == 4) model_tick();
      if (bus.busy) begin
        if (!prev) runs++;
        cur++;
      end else begin
        if (prev) begin
          if (runs == 1) len1 = cur;
          else if (runs == 2) len2 = cur;
          cur = 0;
        end
        if (runs == 1 && len1 > 0) gap++;
      end
      prev = bus.busy;
    end
    total++;
    if (runs != 2) begin bad++; $display("FAIL b2b_loads: got %0d conversions want 2", runs); end
    total++;
    if (len1 != 15 || len2 != 15) begin bad++; $display("FAIL b2b_busy_len: got %0d/%0d want 15/15", len1, len2); end
    total++;
    if (gap != 1) begin bad++; $display("FAIL b2b_gap: got %0d idle cycles want 1", gap); end
    total++;
    if (bus.sel !== 2'(sel_m)) begin bad++; $display("FAIL b2b_sel: got %0d want %0d", bus.sel, sel_m); end
    read_display();
    total++;
    if (obs_val !== 16'h0009) begin bad++; $display("FAIL b2b_val: got %h want 0009", obs_val); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d pending expectations want 0", exp_q.size()); end
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.hold = 1'b0;
    bus.stepcnt = '0;
    bus.distance = '0;
    bus.sec = '0;
    bus.sectime = '0;
    test_reset();
    test_saturate();
    test_rotation();
    test_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
